// File: rtl/rc4_key_search_ctrl.sv
// Top-level sequencer for the RC4 brute-force key search: runs init/swap/decrypt per key, then strides.
// Define KEY_SEARCH_PERF_EN to enable the busy-cycle counter on cycle_count.
module rc4_key_search_ctrl #(
    parameter int KEY_WIDTH  = 24,
    parameter int KEY_STRIDE = 1,
    parameter int CNT_WIDTH  = 24
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic [KEY_WIDTH-1:0] key_start,
    input  logic [KEY_WIDTH-1:0] key_end,
    output logic                 init_start,
    input  logic                 init_done,
    output logic                 swap_start,
    input  logic                 swap_done,
    output logic                 decrypt_start,
    input  logic                 decrypt_done,
    input  logic                 key_found,
    output logic [1:0]           phase_sel,
    output logic [KEY_WIDTH-1:0] secret_key,
    output logic [CNT_WIDTH-1:0] keys_tried,
    output logic                 busy,
    output logic                 done,
    output logic                 found,
    output logic                 exhausted,
    output logic                 aborted,
    output logic [31:0]          cycle_count,
    output logic [2:0]           state_dbg
);

    // Handshake: each *_start is a level request held while its phase is active; the sub-FSM
    // answers with a one-cycle *_done pulse, and the request drops on the following edge.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_SWAP    = 3'd2,
        S_DECRYPT = 3'd3,
        S_NEXT    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [KEY_WIDTH:0]   STRIDE_EXT = (KEY_WIDTH + 1)'(KEY_STRIDE);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    state_t               state_q;
    state_t               state_d;
    logic [KEY_WIDTH-1:0] end_q;
    logic [KEY_WIDTH:0]   next_key;
    logic                 step_ok;
    logic                 range_bad;
    logic                 accept_start;
    logic                 load_key;
    logic                 count_try;
    logic                 advance_key;
    logic                 set_found;
    logic                 set_exhausted;
    logic                 set_aborted;
    logic [1:0]           phase_d;

    // The extra MSB catches a step that wraps past the top of the key space.
    assign next_key  = {1'b0, secret_key} + STRIDE_EXT;
    assign step_ok   = (next_key <= {1'b0, end_q});
    assign range_bad = (key_start > key_end);
    assign state_dbg = state_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        accept_start  = 1'b0;
        load_key      = 1'b0;
        count_try     = 1'b0;
        advance_key   = 1'b0;
        set_found     = 1'b0;
        set_exhausted = 1'b0;
        set_aborted   = 1'b0;
        phase_d       = 2'b00;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    accept_start = 1'b1;
                    if (range_bad) begin
                        set_exhausted = 1'b1;
                        state_d       = S_DONE;
                    end else begin
                        load_key = 1'b1;
                        state_d  = S_INIT;
                    end
                end
            end
            S_INIT: begin
                if (stop) begin
                    set_aborted = 1'b1;
                    state_d     = S_DONE;
                end else if (init_done) begin
                    state_d = S_SWAP;
                end
            end
            S_SWAP: begin
                if (stop) begin
                    set_aborted = 1'b1;
                    state_d     = S_DONE;
                end else if (swap_done) begin
                    state_d = S_DECRYPT;
                end
            end
            S_DECRYPT: begin
                // A found verdict arriving with stop still counts as found.
                if (decrypt_done && key_found) begin
                    count_try = 1'b1;
                    set_found = 1'b1;
                    state_d   = S_DONE;
                end else if (stop) begin
                    set_aborted = 1'b1;
                    state_d     = S_DONE;
                end else if (decrypt_done) begin
                    count_try = 1'b1;
                    state_d   = S_NEXT;
                end
            end
            S_NEXT: begin
                if (stop) begin
                    set_aborted = 1'b1;
                    state_d     = S_DONE;
                end else if (step_ok) begin
                    advance_key = 1'b1;
                    state_d     = S_INIT;
                end else begin
                    set_exhausted = 1'b1;
                    state_d       = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        case (state_d)
            S_INIT:    phase_d = 2'b01;
            S_SWAP:    phase_d = 2'b10;
            S_DECRYPT: phase_d = 2'b11;
            default:   phase_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_start    <= 1'b0;
            swap_start    <= 1'b0;
            decrypt_start <= 1'b0;
            phase_sel     <= 2'b00;
            busy          <= 1'b0;
            done          <= 1'b0;
            found         <= 1'b0;
            exhausted     <= 1'b0;
            aborted       <= 1'b0;
            secret_key    <= '0;
            end_q         <= '0;
            keys_tried    <= '0;
        end else begin
            init_start    <= (state_d == S_INIT);
            swap_start    <= (state_d == S_SWAP);
            decrypt_start <= (state_d == S_DECRYPT);
            phase_sel     <= phase_d;
            busy          <= (state_d == S_INIT) || (state_d == S_SWAP) ||
                             (state_d == S_DECRYPT) || (state_d == S_NEXT);
            done          <= (state_d == S_DONE);

            if (accept_start) begin
                found      <= 1'b0;
                exhausted  <= 1'b0;
                aborted    <= 1'b0;
                keys_tried <= '0;
            end
            if (load_key) begin
                secret_key <= key_start;
                end_q      <= key_end;
            end
            if (count_try && (keys_tried != CNT_MAX)) begin
                keys_tried <= keys_tried + CNT_WIDTH'(1);
            end
            if (advance_key) begin
                secret_key <= next_key[KEY_WIDTH-1:0];
            end
            if (set_found) begin
                found <= 1'b1;
            end
            if (set_exhausted) begin
                exhausted <= 1'b1;
            end
            if (set_aborted) begin
                aborted <= 1'b1;
            end
        end
    end

`ifdef KEY_SEARCH_PERF_EN
    logic [31:0] cycle_q;

    // busy is the registered image of the current state, so this counts cycles spent busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_q <= '0;
        end else if (accept_start) begin
            cycle_q <= '0;
        end else if (busy && (cycle_q != 32'hFFFF_FFFF)) begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    assign cycle_count = cycle_q;
`else
    assign cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Bench for rc4_key_search_ctrl: two instances (24-bit stride 1; 22-bit stride 4 with a 3-bit counter)
// driven by a shared randomised sub-FSM responder, a vector table, random searches and corner sequences.
`timescale 1ns/1ps
module tb_rc4_key_search_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    // ---------------- shared stimulus ----------------
    logic        a_start, b_start, stop;
    logic [23:0] key_start, key_end;
    logic        r_init_done = 1'b0, r_swap_done = 1'b0, r_dec_done = 1'b0, r_found = 1'b0;
    logic        m_init_done = 1'b0, m_swap_done = 1'b0, m_dec_done = 1'b0, m_found = 1'b0;
    logic        init_done, swap_done, decrypt_done, key_found;
    assign init_done    = r_init_done | m_init_done;
    assign swap_done    = r_swap_done | m_swap_done;
    assign decrypt_done = r_dec_done  | m_dec_done;
    assign key_found    = r_found     | m_found;

    // ---------------- instance A outputs ----------------
    logic        a_init_start, a_swap_start, a_dec_start, a_busy, a_done, a_found, a_exh, a_abort;
    logic [1:0]  a_phase;
    logic [23:0] a_key, a_tried;
    logic [31:0] a_cc;
    logic [2:0]  a_state;

    // ---------------- instance B outputs ----------------
    logic        b_init_start, b_swap_start, b_dec_start, b_busy, b_done, b_found, b_exh, b_abort;
    logic [1:0]  b_phase;
    logic [21:0] b_key;
    logic [2:0]  b_tried;
    logic [31:0] b_cc;
    logic [2:0]  b_state;

    rc4_key_search_ctrl #(.KEY_WIDTH(24), .KEY_STRIDE(1), .CNT_WIDTH(24)) u_a (
        .clk(clk), .reset_n(reset_n), .start(a_start), .stop(stop),
        .key_start(key_start), .key_end(key_end),
        .init_start(a_init_start), .init_done(init_done),
        .swap_start(a_swap_start), .swap_done(swap_done),
        .decrypt_start(a_dec_start), .decrypt_done(decrypt_done), .key_found(key_found),
        .phase_sel(a_phase), .secret_key(a_key), .keys_tried(a_tried),
        .busy(a_busy), .done(a_done), .found(a_found), .exhausted(a_exh), .aborted(a_abort),
        .cycle_count(a_cc), .state_dbg(a_state)
    );

    rc4_key_search_ctrl #(.KEY_WIDTH(22), .KEY_STRIDE(4), .CNT_WIDTH(3)) u_b (
        .clk(clk), .reset_n(reset_n), .start(b_start), .stop(stop),
        .key_start(key_start[21:0]), .key_end(key_end[21:0]),
        .init_start(b_init_start), .init_done(init_done),
        .swap_start(b_swap_start), .swap_done(swap_done),
        .decrypt_start(b_dec_start), .decrypt_done(decrypt_done), .key_found(key_found),
        .phase_sel(b_phase), .secret_key(b_key), .keys_tried(b_tried),
        .busy(b_busy), .done(b_done), .found(b_found), .exhausted(b_exh), .aborted(b_abort),
        .cycle_count(b_cc), .state_dbg(b_state)
    );

    // ---------------- view of the selected instance ----------------
    bit          sel = 1'b0;
    logic        v_init_start, v_swap_start, v_dec_start, v_busy, v_done, v_found, v_exh, v_abort;
    logic [1:0]  v_phase;
    logic [31:0] v_key, v_tried, v_cc;
    assign v_init_start = sel ? b_init_start : a_init_start;
    assign v_swap_start = sel ? b_swap_start : a_swap_start;
    assign v_dec_start  = sel ? b_dec_start  : a_dec_start;
    assign v_busy       = sel ? b_busy       : a_busy;
    assign v_done       = sel ? b_done       : a_done;
    assign v_found      = sel ? b_found      : a_found;
    assign v_exh        = sel ? b_exh        : a_exh;
    assign v_abort      = sel ? b_abort      : a_abort;
    assign v_phase      = sel ? b_phase      : a_phase;
    assign v_key        = sel ? {10'd0, b_key}   : {8'd0, a_key};
    assign v_tried      = sel ? {29'd0, b_tried} : {8'd0, a_tried};
    assign v_cc         = sel ? b_cc : a_cc;

    // ---------------- scoreboard counters ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- sub-FSM responder (random latency) ----------------
    bit          resp_en = 1'b0;
    bit          has_t_g = 1'b0;
    logic [31:0] tgt_g   = '0;
    int          wait_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            r_init_done = 1'b0;
            r_swap_done = 1'b0;
            r_dec_done  = 1'b0;
            r_found     = 1'b0;
            if (resp_en) begin
                // key_found noise outside decrypt_done must be ignored
                r_found = 1'($urandom_range(0, 1));
                if (v_init_start || v_swap_start || v_dec_start) begin
                    if (wait_cnt == 0) begin
                        if (v_init_start) r_init_done = 1'b1;
                        else if (v_swap_start) r_swap_done = 1'b1;
                        else begin
                            r_dec_done = 1'b1;
                            r_found    = has_t_g && (v_key == tgt_g);
                        end
                        wait_cnt = $urandom_range(0, 3);
                    end else begin
                        wait_cnt--;
                    end
                end
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic void model(input bit inst, input longint ks, input longint ke,
                                  input bit has_t, input longint tgt,
                                  output bit e_found, output bit e_exh,
                                  output logic [31:0] e_key, output logic [31:0] e_tried);
        longint stride, cmax, tried;
        stride  = inst ? 4 : 1;
        cmax    = inst ? 7 : 64'hFF_FFFF;
        e_found = 1'b0;
        e_key   = 32'(ks);
        tried   = 0;
        for (longint k = ks; k <= ke; k += stride) begin
            tried++;
            e_key = 32'(k);
            if (has_t && k == tgt) begin
                e_found = 1'b1;
                break;
            end
        end
        e_exh   = !e_found;
        e_tried = 32'((tried > cmax) ? cmax : tried);
    endfunction

    // ---------------- driver tasks ----------------
    int n_cyc;
    bit saw_init;

    task automatic pulse_start(input bit inst, input logic [23:0] ks, input logic [23:0] ke);
        @(negedge clk);
        sel       = inst;
        key_start = ks;
        key_end   = ke;
        if (inst) b_start = 1'b1; else a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        b_start = 1'b0;
    endtask

    task automatic run_search(input bit inst, input logic [23:0] ks, input logic [23:0] ke,
                              input bit has_t, input logic [31:0] tgt);
        has_t_g = has_t;
        tgt_g   = tgt;
        resp_en = 1'b1;
        pulse_start(inst, ks, ke);
        n_cyc    = 1;
        saw_init = v_init_start;
        while (!v_done && n_cyc < 4000) begin
            @(negedge clk);
            n_cyc++;
            if (v_init_start) saw_init = 1'b1;
        end
        check("search_terminates", 32'(v_done), 32'd1);
    endtask

    task automatic check_result(input string tag, input bit e_found, input bit e_exh,
                                input bit chk_key, input logic [31:0] e_key,
                                input logic [31:0] e_tried);
        logic [31:0] exp_cc;
`ifdef KEY_SEARCH_PERF_EN
        exp_cc = 32'(n_cyc - 1);
`else
        exp_cc = 32'd0;
`endif
        check({tag, "_done"},      32'(v_done),  32'd1);
        check({tag, "_found"},     32'(v_found), 32'(e_found));
        check({tag, "_exhausted"}, 32'(v_exh),   32'(e_exh));
        check({tag, "_aborted"},   32'(v_abort), 32'd0);
        check({tag, "_idle_outs"}, {27'd0, v_busy, v_init_start, v_swap_start, v_phase}, 32'd0);
        check({tag, "_keys_tried"}, v_tried, e_tried);
        if (chk_key) check({tag, "_secret_key"}, v_key, e_key);
        check({tag, "_cycle_count"}, v_cc, exp_cc);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a_flags"}, {22'd0, a_init_start, a_swap_start, a_dec_start, a_phase,
                                  a_busy, a_done, a_found, a_exh, a_abort}, 32'd0);
        check({tag, "_a_key"},   {8'd0, a_key},   32'd0);
        check({tag, "_a_tried"}, {8'd0, a_tried}, 32'd0);
        check({tag, "_a_cc"},    a_cc,            32'd0);
        check({tag, "_b_flags"}, {22'd0, b_init_start, b_swap_start, b_dec_start, b_phase,
                                  b_busy, b_done, b_found, b_exh, b_abort}, 32'd0);
        check({tag, "_b_key"},   {10'd0, b_key},  32'd0);
        check({tag, "_b_tried"}, {29'd0, b_tried}, 32'd0);
        check({tag, "_b_cc"},    b_cc,            32'd0);
    endtask

    task automatic pulse_manual(input int which);
        @(negedge clk);
        case (which)
            0: m_init_done = 1'b1;
            1: m_swap_done = 1'b1;
            default: m_dec_done = 1'b1;
        endcase
        @(negedge clk);
        m_init_done = 1'b0;
        m_swap_done = 1'b0;
        m_dec_done  = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          inst;
        logic [31:0] ks, ke, tgt;
        bit          has_t;
        bit          e_found, e_exh, chk_key;
        logic [31:0] e_key, e_tried;
    } vec_t;
    vec_t vecs[8];

    // ---------------- global watchdog ----------------
    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        bit          inst, e_found, e_exh, has_t;
        logic [31:0] ks, ke, kmax, tgt, e_key, e_tried, stride;
        int          bound;

        vecs[0] = '{1'b0, 32'h240,    32'h24F,    32'h249, 1'b1, 1'b1, 1'b0, 1'b1, 32'h249,    32'd10};
        vecs[1] = '{1'b1, 32'h1,      32'h10,     32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 32'hD,      32'd4};
        vecs[2] = '{1'b1, 32'h3FFFFF, 32'h3FFFFF, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 32'h3FFFFF, 32'd1};
        vecs[3] = '{1'b0, 32'h10,     32'h8,      32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 32'h0,      32'd0};
        vecs[4] = '{1'b0, 32'hFFFFFF, 32'hFFFFFF, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFFFF, 32'd1};
        vecs[5] = '{1'b1, 32'h0,      32'h27,     32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 32'h24,     32'd7};
        vecs[6] = '{1'b0, 32'h5,      32'h5,      32'h5,   1'b1, 1'b1, 1'b0, 1'b1, 32'h5,      32'd1};
        vecs[7] = '{1'b1, 32'h100,    32'h1FF,    32'h108, 1'b1, 1'b1, 1'b0, 1'b1, 32'h108,    32'd3};

        reset_n   = 1'b0;
        a_start   = 1'b0;
        b_start   = 1'b0;
        stop      = 1'b0;
        key_start = '0;
        key_end   = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;

        // stop while idle does nothing
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_in_idle", {29'd0, a_busy, a_done, a_abort}, 32'd0);

        // table-driven searches
        foreach (vecs[i]) begin
            run_search(vecs[i].inst, vecs[i].ks[23:0], vecs[i].ke[23:0], vecs[i].has_t, vecs[i].tgt);
            check_result($sformatf("vec%0d", i), vecs[i].e_found, vecs[i].e_exh,
                         vecs[i].chk_key, vecs[i].e_key, vecs[i].e_tried);
            if (vecs[i].ks > vecs[i].ke) begin
                check($sformatf("vec%0d_done_latency", i), 32'(n_cyc), 32'd1);
                check($sformatf("vec%0d_no_init_start", i), 32'(saw_init), 32'd0);
            end
        end

        // randomised searches against the model
        for (int i = 0; i < 14; i++) begin
            inst   = 1'($urandom_range(0, 1));
            kmax   = inst ? 32'h3F_FFFF : 32'hFF_FFFF;
            stride = inst ? 32'd4 : 32'd1;
            case ($urandom_range(0, 2))
                0:       ks = kmax - $urandom_range(0, 12);
                1:       ks = $urandom_range(0, 64);
                default: ks = $urandom & kmax;
            endcase
            ke = ks + $urandom_range(0, 40);
            if (ke > kmax) ke = kmax;
            if ($urandom_range(0, 5) == 0 && ks > 0) ke = ks - 1;
            has_t = 1'($urandom_range(0, 1));
            tgt   = ks + stride * $urandom_range(0, 12);
            model(inst, longint'(ks), longint'(ke), has_t, longint'(tgt), e_found, e_exh, e_key, e_tried);
            run_search(inst, ks[23:0], ke[23:0], has_t, tgt);
            check_result($sformatf("rand%0d", i), e_found, e_exh, ks <= ke, e_key, e_tried);
        end

        // hand sequence: handshake latency, stray dones, start while busy, stop
        resp_en = 1'b0;
        @(negedge clk);
        pulse_start(1'b0, 24'h10, 24'h20);
        check("lat_start_to_init", {29'd0, v_init_start, v_swap_start, v_dec_start}, 32'd4);
        check("init_phase_sel", 32'(v_phase), 32'd1);
        check("init_loaded_key", v_key, 32'h10);
        check("init_busy_tried", {v_busy, v_tried[30:0]}, 32'h8000_0000);
        @(negedge clk);
        m_swap_done = 1'b1;
        m_dec_done  = 1'b1;
        m_found     = 1'b1;
        @(negedge clk);
        m_swap_done = 1'b0;
        m_dec_done  = 1'b0;
        m_found     = 1'b0;
        check("stray_done_in_init", {29'd0, v_init_start, v_swap_start, v_dec_start}, 32'd4);
        pulse_manual(0);
        check("swap_after_init_done", {29'd0, v_init_start, v_swap_start, v_dec_start}, 32'd2);
        check("swap_phase_sel", 32'(v_phase), 32'd2);
        pulse_manual(0);
        check("stray_init_done_in_swap", {29'd0, v_init_start, v_swap_start, v_dec_start}, 32'd2);
        pulse_manual(1);
        check("decrypt_after_swap_done", {29'd0, v_init_start, v_swap_start, v_dec_start}, 32'd1);
        check("decrypt_phase_sel", 32'(v_phase), 32'd3);
        pulse_manual(2);
        check("next_starts_low", {29'd0, v_init_start, v_swap_start, v_dec_start}, 32'd0);
        check("next_busy", 32'(v_busy), 32'd1);
        check("next_keys_tried", v_tried, 32'd1);
        @(negedge clk);
        check("lat_decrypt_done_to_init", 32'(v_init_start), 32'd1);
        check("stepped_key", v_key, 32'h11);
        a_start   = 1'b1;
        key_start = 24'h500;
        key_end   = 24'h600;
        @(negedge clk);
        a_start = 1'b0;
        check("start_while_busy_key", v_key, 32'h11);
        check("start_while_busy_state", {29'd0, v_init_start, v_busy, v_done}, 32'd6);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_init_done", {28'd0, v_done, v_abort, v_found, v_exh}, 32'hC);
        check("stop_init_frozen_key", v_key, 32'h11);
        check("stop_init_frozen_tried", v_tried, 32'd1);

        // stop during SWAP of the third key
        run_search(1'b0, 24'h2F0, 24'h2F0, 1'b0, 32'h0);
        has_t_g = 1'b0;
        resp_en = 1'b1;
        pulse_start(1'b0, 24'h300, 24'h3FF);
        bound = 0;
        while (!(v_swap_start && v_tried == 32'd2) && bound < 2000) begin
            @(negedge clk);
            bound++;
        end
        check("reach_third_swap", 32'(bound < 2000), 32'd1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_swap_flags", {28'd0, v_done, v_abort, v_found, v_exh}, 32'hC);
        check("stop_swap_tried", v_tried, 32'd2);
        check("stop_swap_key", v_key, 32'h302);

        // stop together with a found verdict
        resp_en = 1'b0;
        @(negedge clk);
        pulse_start(1'b0, 24'h700, 24'h70F);
        pulse_manual(0);
        pulse_manual(1);
        @(negedge clk);
        m_dec_done = 1'b1;
        m_found    = 1'b1;
        stop       = 1'b1;
        @(negedge clk);
        m_dec_done = 1'b0;
        m_found    = 1'b0;
        stop       = 1'b0;
        check("stop_vs_found_flags", {28'd0, v_done, v_abort, v_found, v_exh}, 32'hA);
        check("stop_vs_found_key", v_key, 32'h700);
        check("stop_vs_found_tried", v_tried, 32'd1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_in_done_ignored", {28'd0, v_done, v_abort, v_found, v_exh}, 32'hA);

        // asynchronous reset during DECRYPT
        has_t_g = 1'b0;
        resp_en = 1'b1;
        pulse_start(1'b0, 24'h800, 24'h80F);
        bound = 0;
        while (!v_dec_start && bound < 200) begin
            @(negedge clk);
            bound++;
        end
        check("reach_decrypt", 32'(v_dec_start), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        run_search(1'b0, 24'h20, 24'h22, 1'b1, 32'h21);
        check_result("after_reset", 1'b1, 1'b0, 1'b1, 32'h21, 32'd2);

        resp_en = 1'b0;
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
